// File: rtl/prng_sched.sv
// prng_sched: seeds and warms up prng_unit, then shares its output among NREQ cores by round-robin grant.
// Registered one-cycle grant; supports on-demand reseed from SERVE.
module prng_sched #(
   parameter int NREQ          = 2,
   parameter int SIZE_FEED     = 32,
   parameter int SEED_WORDS    = 4,
   parameter int WARMUP_CYCLES = 256
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 seed_valid,
   input  logic [SIZE_FEED-1:0] seed_data,
   output logic                 seed_ready,
   input  logic                 reseed_req,
   input  logic [NREQ-1:0]      req,
   output logic [NREQ-1:0]      gnt,
   output logic                 seeded,
   output logic                 prng_pre_rst,
   output logic                 prng_feed,
   output logic [SIZE_FEED-1:0] prng_feed_data,
   output logic                 prng_pre_enable_run,
   input  logic                 prng_rnd_valid
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int WW = $clog2(SEED_WORDS) + 1;
   localparam int CW = $clog2(WARMUP_CYCLES) + 1;
   typedef enum logic [1:0] {RST_PRNG, LOAD, WARMUP, SERVE} state_t;
   state_t state, state_nxt;
   logic [WW-1:0] word_cnt;
   logic [CW-1:0] warm_cnt;
   logic [PW-1:0] rr_ptr, win;
   logic [NREQ-1:0] elig;
   logic accept, issue;
   int best, d;
   // the core being granted this cycle still holds req, so it is masked out
   always_comb begin
      elig = req & ~gnt;
      win = rr_ptr;
      best = NREQ;
      d = 0;
      for (int j = 0; j < NREQ; j++) begin
         d = (j + NREQ - 1 - int'(rr_ptr)) % NREQ;
         if (elig[j] && d < best) begin
            best = d;
            win = PW'(j);
         end
      end
   end
   always_comb begin
      state_nxt = state;
      seed_ready = 1'b0;
      prng_feed = 1'b0;
      prng_feed_data = '0;
      prng_pre_enable_run = 1'b0;
      prng_pre_rst = 1'b0;
      accept = 1'b0;
      issue = 1'b0;
      case (state)
         RST_PRNG: begin
            prng_pre_rst = 1'b1;
            state_nxt = LOAD;
         end
         LOAD: begin
            seed_ready = 1'b1;
            accept = seed_valid;
            prng_feed = seed_valid;
            prng_feed_data = seed_valid ? seed_data : '0;
            state_nxt = (accept && word_cnt == WW'(SEED_WORDS - 1)) ? WARMUP : LOAD;
         end
         WARMUP: begin
            prng_pre_enable_run = 1'b1;
            state_nxt = (warm_cnt == CW'(WARMUP_CYCLES - 1)) ? SERVE : WARMUP;
         end
         default: begin
            // a pending reseed suppresses both issue and refill
            issue = prng_rnd_valid && |elig && !reseed_req;
            prng_pre_enable_run = !reseed_req && (!prng_rnd_valid || issue);
            state_nxt = reseed_req ? LOAD : SERVE;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= RST_PRNG;
      else state <= state_nxt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         word_cnt <= '0;
         warm_cnt <= '0;
         rr_ptr <= PW'(NREQ - 1);
         gnt <= '0;
         seeded <= 1'b0;
      end else begin
         word_cnt <= (state == LOAD && state_nxt == LOAD) ? word_cnt + WW'(accept) : '0;
         warm_cnt <= (state == WARMUP && state_nxt == WARMUP) ? warm_cnt + CW'(1) : '0;
         gnt <= issue ? NREQ'(1) << win : '0;
         rr_ptr <= issue ? win : rr_ptr;
         seeded <= (state_nxt == SERVE);
      end
endmodule

// File: tb/tb_prng_sched.sv
// tb_prng_sched: directed bench for prng_sched with hand-computed expectations.
module tb_prng_sched;
   logic clk = 1'b0, rst_n = 1'b0;
   logic seed_valid = 1'b0, reseed_req = 1'b0, prng_rnd_valid = 1'b0;
   logic [31:0] seed_data = '0;
   logic [1:0] req = '0;
   logic seed_ready, seeded, prng_pre_rst, prng_feed, prng_pre_enable_run;
   logic [31:0] prng_feed_data;
   logic [1:0] gnt;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   prng_sched dut (
      .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_data(seed_data),
      .seed_ready(seed_ready), .reseed_req(reseed_req), .req(req), .gnt(gnt),
      .seeded(seeded), .prng_pre_rst(prng_pre_rst), .prng_feed(prng_feed),
      .prng_feed_data(prng_feed_data), .prng_pre_enable_run(prng_pre_enable_run),
      .prng_rnd_valid(prng_rnd_valid)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask
   task automatic step;
      @(posedge clk);
      #1;
   endtask
   task automatic load_seed(input logic [31:0] base, input logic [31:0] inc);
      logic [31:0] w_data;
      for (int w = 0; w < 4; w++) begin
         w_data = base + inc * 32'(w);
         seed_valid = 1'b1;
         seed_data = w_data;
         #1;
         chk("feed", prng_feed, 1);
         chk("feed_data", prng_feed_data, w_data);
         chk("feed_no_en", prng_pre_enable_run, 0);
         step;
      end
      seed_valid = 1'b0;
      seed_data = '0;
      #1;
      chk("ready_drop", seed_ready, 0);
      chk("warm_en", prng_pre_enable_run, 1);
   endtask
   // junk seeds and reseed requests are offered throughout warm-up and must be ignored
   task automatic warmup(input int n);
      int en, fd;
      en = 0;
      fd = 0;
      seed_valid = 1'b1;
      seed_data = 32'hDEADBEEF;
      for (int i = 0; i < n; i++) begin
         reseed_req = (i < 10);
         #1;
         en += int'(prng_pre_enable_run);
         fd += int'(prng_feed | seed_ready);
         if (i == n - 1) chk("seeded_early", seeded, 0);
         step;
      end
      seed_valid = 1'b0;
      reseed_req = 1'b0;
      chk("warm_en_cnt", en, n);
      chk("warm_no_feed", fd, 0);
   endtask
   always @(negedge clk) chk("feed_en_excl", prng_feed & prng_pre_enable_run, 0);
   initial begin
      #3;
      chk("rst_pre_rst", prng_pre_rst, 1);
      chk("rst_ready", seed_ready, 0);
      chk("rst_en", prng_pre_enable_run, 0);
      chk("rst_gnt", gnt, 0);
      chk("rst_seeded", seeded, 0);
      step;
      step;
      rst_n = 1'b1;
      #1;
      chk("pre_rst_hold", prng_pre_rst, 1);
      chk("ready_in_rstprng", seed_ready, 0);
      step;
      chk("pre_rst_end", prng_pre_rst, 0);
      chk("load_ready", seed_ready, 1);
      load_seed(32'h11111111, 32'h11111111);
      warmup(256);
      #1;
      chk("seeded_set", seeded, 1);
      chk("refill_en", prng_pre_enable_run, 1);
      chk("serve_gnt0", gnt, 0);
      step;
      req = 2'b11;
      prng_rnd_valid = 1'b1;
      #1;
      chk("issue0_en", prng_pre_enable_run, 1);
      chk("issue0_nognt", gnt, 0);
      step;
      req = 2'b10;
      #1;
      chk("gnt_core0", gnt, 2'b01);
      chk("issue1_en", prng_pre_enable_run, 1);
      step;
      req = 2'b00;
      #1;
      chk("gnt_core1", gnt, 2'b10);
      chk("stall_en", prng_pre_enable_run, 0);
      step;
      req = 2'b01;
      #1;
      chk("t4_issue_en", prng_pre_enable_run, 1);
      chk("t4_issue_nognt", gnt, 0);
      step;
      req = 2'b00;
      prng_rnd_valid = 1'b0;
      #1;
      chk("t4_gnt", gnt, 2'b01);
      chk("t4_refill", prng_pre_enable_run, 1);
      for (int k = 0; k < 3; k++) begin
         step;
         req = 2'b01;
         #1;
         chk("t4_wait_en", prng_pre_enable_run, 1);
         chk("t4_wait_nognt", gnt, 0);
      end
      step;
      prng_rnd_valid = 1'b1;
      #1;
      chk("t4_reissue_en", prng_pre_enable_run, 1);
      step;
      req = 2'b00;
      #1;
      chk("t4_regnt", gnt, 2'b01);
      step;
      req = 2'b11;
      #1;
      chk("rr0_issue_en", prng_pre_enable_run, 1);
      step;
      req = 2'b01;
      #1;
      chk("rr0_core1", gnt, 2'b10);
      chk("rr0_next_en", prng_pre_enable_run, 1);
      step;
      req = 2'b00;
      #1;
      chk("rr0_core0", gnt, 2'b01);
      step;
      req = 2'b11;
      #1;
      chk("t5_issue_en", prng_pre_enable_run, 1);
      step;
      req = 2'b01;
      reseed_req = 1'b1;
      #1;
      chk("t5_gnt_completes", gnt, 2'b10);
      chk("t5_no_en", prng_pre_enable_run, 0);
      chk("t5_seeded_still", seeded, 1);
      step;
      reseed_req = 1'b0;
      req = 2'b00;
      #1;
      chk("t5_seeded_clr", seeded, 0);
      chk("t5_ready", seed_ready, 1);
      chk("t5_gnt_clr", gnt, 0);
      chk("t5_no_pre_rst", prng_pre_rst, 0);
      load_seed(32'h01020304, 32'h10101010);
      warmup(100);
      seed_valid = 1'b1;
      seed_data = 32'hCAFEF00D;
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_pre_rst", prng_pre_rst, 1);
      chk("abort_en", prng_pre_enable_run, 0);
      chk("abort_ready", seed_ready, 0);
      chk("abort_feed", prng_feed, 0);
      chk("abort_feed_data", prng_feed_data, 0);
      chk("abort_seeded", seeded, 0);
      seed_valid = 1'b0;
      step;
      rst_n = 1'b1;
      #1;
      chk("rerst_pre_rst", prng_pre_rst, 1);
      step;
      chk("rerst_ready", seed_ready, 1);
      load_seed(32'hA5A5A5A5, 32'h01010101);
      warmup(256);
      #1;
      chk("reseeded", seeded, 1);
      step;
      req = 2'b11;
      step;
      req = 2'b10;
      #1;
      chk("post_rst_core0", gnt, 2'b01);
      step;
      req = 2'b00;
      #1;
      chk("post_rst_core1", gnt, 2'b10);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
